// File: rtl/adsr_poly_if.sv
// Settings, gates and envelope status bundle for adsr_poly.
// master drives gates/settings, slave is the envelope bank.
interface adsr_poly_if #(
    parameter int NUM_CH = 4,
    parameter int W      = 32,
    parameter int OUT_W  = 16,
    parameter int TW     = 32
);
    logic [NUM_CH-1:0]       i_gate;
    logic                    i_one_shot;
    logic [W-1:0]            i_attack_step;
    logic [W-1:0]            i_decay_step;
    logic [W-1:0]            i_sustain_level;
    logic [W-1:0]            i_release_step;
    logic [TW-1:0]           i_sustain_time;
    logic [NUM_CH*OUT_W-1:0] o_env;
    logic [NUM_CH*3-1:0]     o_phase;
    logic [NUM_CH-1:0]       o_active;
    logic [NUM_CH-1:0]       o_done;

    modport master (
        output i_gate, i_one_shot,
        output i_attack_step, i_decay_step,
        output i_sustain_level, i_release_step,
        output i_sustain_time,
        input  o_env, o_phase, o_active, o_done
    );

    modport slave (
        input  i_gate, i_one_shot,
        input  i_attack_step, i_decay_step,
        input  i_sustain_level, i_release_step,
        input  i_sustain_time,
        output o_env, o_phase, o_active, o_done
    );
endinterface

// File: rtl/adsr_poly.sv
// Multi-channel ADSR envelope bank with shared settings,
// gate or one-shot sustain, and selectable retrigger policy.
module adsr_poly #(
    parameter int NUM_CH      = 4,
    parameter int W           = 32,
    parameter int OUT_W       = 16,
    parameter int TW          = 32,
    parameter bit RETRIG_ZERO = 1'b1
) (
    input logic       i_clk,
    input logic       i_reset,
    adsr_poly_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } phase_t;

    localparam logic [W-1:0] FS = {1'b1, {(W-1){1'b0}}};

    phase_t            r_ph  [NUM_CH];
    phase_t            w_ph  [NUM_CH];
    logic [W-1:0]      r_lvl [NUM_CH];
    logic [W-1:0]      w_lvl [NUM_CH];
    logic [TW-1:0]     r_t   [NUM_CH];
    logic [TW-1:0]     w_t   [NUM_CH];
    logic [W:0]        w_sum [NUM_CH];
    logic [NUM_CH-1:0] r_gq;
    logic [NUM_CH-1:0] r_done;
    logic [NUM_CH-1:0] w_done;
    logic [W-1:0]      w_sus;

    assign w_sus = (bus.i_sustain_level > FS) ? FS
                 : bus.i_sustain_level;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_ph[c]  <= IDLE;
                r_lvl[c] <= '0;
                r_t[c]   <= '0;
            end
            r_gq   <= '0;
            r_done <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_ph[c]  <= w_ph[c];
                r_lvl[c] <= w_lvl[c];
                r_t[c]   <= w_t[c];
            end
            r_gq   <= bus.i_gate;
            r_done <= w_done;
        end
    end

    // Per channel: trigger beats fall beats the phase update.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_ph[c]   = r_ph[c];
            w_lvl[c]  = r_lvl[c];
            w_t[c]    = r_t[c];
            w_done[c] = 1'b0;
            w_sum[c]  = {1'b0, r_lvl[c]}
                      + {1'b0, bus.i_attack_step};
            if (bus.i_gate[c] && !r_gq[c]) begin
                w_ph[c] = ATTACK;
                w_t[c]  = '0;
                if (RETRIG_ZERO)
                    w_lvl[c] = '0;
            end else if (!bus.i_gate[c] && r_gq[c] &&
                         !bus.i_one_shot &&
                         (r_ph[c] inside
                          {ATTACK, DECAY, SUSTAIN})) begin
                w_ph[c] = RELEASE;
            end else begin
                unique case (r_ph[c])
                    ATTACK: begin
                        if (bus.i_attack_step == '0 ||
                            w_sum[c] >= {1'b0, FS}) begin
                            w_lvl[c] = FS;
                            w_ph[c]  = DECAY;
                        end else begin
                            w_lvl[c] = w_sum[c][W-1:0];
                        end
                    end
                    DECAY: begin
                        if (bus.i_decay_step == '0 ||
                            r_lvl[c] < bus.i_decay_step ||
                            (r_lvl[c] - bus.i_decay_step)
                              <= w_sus) begin
                            w_lvl[c] = w_sus;
                            w_ph[c]  = SUSTAIN;
                            w_t[c]   = '0;
                        end else begin
                            w_lvl[c] = r_lvl[c]
                                     - bus.i_decay_step;
                        end
                    end
                    SUSTAIN: begin
                        if (bus.i_one_shot) begin
                            if (r_t[c] < bus.i_sustain_time)
                                w_t[c] = r_t[c] + 1'b1;
                            else
                                w_ph[c] = RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (bus.i_release_step == '0 ||
                            r_lvl[c] <= bus.i_release_step) begin
                            w_lvl[c]  = '0;
                            w_ph[c]   = IDLE;
                            w_done[c] = 1'b1;
                        end else begin
                            w_lvl[c] = r_lvl[c]
                                     - bus.i_release_step;
                        end
                    end
                    default: begin
                        w_lvl[c] = '0;
                        w_ph[c]  = IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign bus.o_env[c*OUT_W +: OUT_W] =
            {1'b0, r_lvl[c][W-1 -: OUT_W-1]};
        assign bus.o_phase[c*3 +: 3] = r_ph[c];
        assign bus.o_active[c]       = (r_ph[c] != IDLE);
    end

    assign bus.o_done = r_done;
endmodule

// File: tb/tb_adsr_poly.sv
// Bench for adsr_poly: directed table and sequences plus
// randomized gates/settings against an arithmetic model.
module tb_adsr_poly;
    localparam int NUM_CH = 4;
    localparam int W      = 32;
    localparam int OUT_W  = 16;
    localparam int TW     = 32;
    localparam longint unsigned FS = 64'h8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] gate;
    logic              os;
    logic [W-1:0]      as_, ds, sl, rs;
    logic [TW-1:0]     st;

    int n_chk  = 0;
    int n_fail = 0;

    adsr_poly_if #(.NUM_CH(NUM_CH), .W(W), .OUT_W(OUT_W),
                   .TW(TW)) b0 ();
    adsr_poly_if #(.NUM_CH(NUM_CH), .W(W), .OUT_W(OUT_W),
                   .TW(TW)) b1 ();

    assign b0.i_gate          = gate;
    assign b0.i_one_shot      = os;
    assign b0.i_attack_step   = as_;
    assign b0.i_decay_step    = ds;
    assign b0.i_sustain_level = sl;
    assign b0.i_release_step  = rs;
    assign b0.i_sustain_time  = st;
    assign b1.i_gate          = gate;
    assign b1.i_one_shot      = os;
    assign b1.i_attack_step   = as_;
    assign b1.i_decay_step    = ds;
    assign b1.i_sustain_level = sl;
    assign b1.i_release_step  = rs;
    assign b1.i_sustain_time  = st;

    adsr_poly #(.NUM_CH(NUM_CH), .W(W), .OUT_W(OUT_W),
                .TW(TW), .RETRIG_ZERO(1'b1)) u_dut (
        .i_clk(clk), .i_reset(rst), .bus(b0));
    adsr_poly #(.NUM_CH(NUM_CH), .W(W), .OUT_W(OUT_W),
                .TW(TW), .RETRIG_ZERO(1'b0)) u_leg (
        .i_clk(clk), .i_reset(rst), .bus(b1));

    always #5 clk = ~clk;

    // Reference: instance 0 restarts from 0, instance 1 is legato.
    int              m_ph   [2][NUM_CH];
    longint unsigned m_l    [2][NUM_CH];
    longint unsigned m_t    [2][NUM_CH];
    bit              m_gq   [2][NUM_CH];
    bit              m_done [2][NUM_CH];

    always @(posedge clk or posedge rst) begin
        longint unsigned s;
        bit g;
        s = (sl > FS) ? FS : longint'(sl);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NUM_CH; c++) begin
                if (rst) begin
                    m_ph[k][c] = 0; m_l[k][c] = 0;
                    m_t[k][c] = 0; m_gq[k][c] = 0;
                    m_done[k][c] = 0;
                    continue;
                end
                g = gate[c];
                m_done[k][c] = 0;
                if (g && !m_gq[k][c]) begin
                    m_ph[k][c] = 1; m_t[k][c] = 0;
                    if (k == 0) m_l[k][c] = 0;
                end else if (!g && m_gq[k][c] && !os &&
                             m_ph[k][c] >= 1 &&
                             m_ph[k][c] <= 3) begin
                    m_ph[k][c] = 4;
                end else if (m_ph[k][c] == 1) begin
                    if (as_ == 0 || m_l[k][c] + as_ >= FS) begin
                        m_l[k][c] = FS; m_ph[k][c] = 2;
                    end else m_l[k][c] += as_;
                end else if (m_ph[k][c] == 2) begin
                    if (ds == 0 || m_l[k][c] < ds ||
                        m_l[k][c] - ds <= s) begin
                        m_l[k][c] = s; m_ph[k][c] = 3;
                        m_t[k][c] = 0;
                    end else m_l[k][c] -= ds;
                end else if (m_ph[k][c] == 3) begin
                    if (os) begin
                        if (m_t[k][c] < st) m_t[k][c]++;
                        else m_ph[k][c] = 4;
                    end
                end else if (m_ph[k][c] == 4) begin
                    if (rs == 0 || m_l[k][c] <= rs) begin
                        m_l[k][c] = 0; m_ph[k][c] = 0;
                        m_done[k][c] = 1;
                    end else m_l[k][c] -= rs;
                end
                m_gq[k][c] = g;
            end
    end

    task automatic chk(string nm, logic [63:0] got,
                       logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, got, exp);
        end
    endtask

    task automatic cmp(int k, logic [NUM_CH*OUT_W-1:0] e,
                       logic [NUM_CH*3-1:0] p,
                       logic [NUM_CH-1:0] a,
                       logic [NUM_CH-1:0] d);
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("m%0d_env%0d", k, c),
                64'(e[c*OUT_W +: OUT_W]),
                (m_l[k][c] >> (W - OUT_W + 1)));
            chk($sformatf("m%0d_ph%0d", k, c),
                64'(p[c*3 +: 3]), 64'(m_ph[k][c]));
            chk($sformatf("m%0d_act%0d", k, c),
                64'(a[c]), 64'(m_ph[k][c] != 0));
            chk($sformatf("m%0d_done%0d", k, c),
                64'(d[c]), 64'(m_done[k][c]));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp(0, b0.o_env, b0.o_phase,
                b0.o_active, b0.o_done);
            cmp(1, b1.o_env, b1.o_phase,
                b1.o_active, b1.o_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        gate = '0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [NUM_CH-1:0] gate;
        logic [15:0]       env;
        logic [2:0]        ph;
        logic              done;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        tbl[0] = '{4'b0000, 16'h2000, 3'd4, 1'b0};
        tbl[1] = '{4'b0000, 16'h1800, 3'd4, 1'b0};
        tbl[2] = '{4'b0000, 16'h1000, 3'd4, 1'b0};
        tbl[3] = '{4'b0000, 16'h0800, 3'd4, 1'b0};
        tbl[4] = '{4'b0000, 16'h0000, 3'd0, 1'b1};
        tbl[5] = '{4'b0000, 16'h0000, 3'd0, 1'b0};

        rst = 1'b1; gate = '0; os = 1'b0;
        as_ = '0; ds = '0; sl = '0; rs = '0; st = '0;
        repeat (3) tick();
        chk("rst_env", 64'(b0.o_env), 64'd0);
        chk("rst_phase", 64'(b0.o_phase), 64'd0);
        chk("rst_active", 64'(b0.o_active), 64'd0);
        chk("rst_done", 64'(b0.o_done), 64'd0);
        rst = 1'b0;
        tick();

        as_ = 32'h1000_0000; ds = 32'h0800_0000;
        sl  = 32'h4000_0000; rs = 32'h1000_0000;
        gate = 4'b0001;
        tick();
        chk("trig_ph", 64'(b0.o_phase[2:0]), 64'd1);
        chk("trig_env", 64'(b0.o_env[15:0]), 64'd0);
        repeat (7) tick();
        chk("att7_env", 64'(b0.o_env[15:0]), 64'h3800);
        tick();
        chk("att8_env", 64'(b0.o_env[15:0]), 64'h4000);
        chk("att8_ph", 64'(b0.o_phase[2:0]), 64'd2);
        repeat (8) tick();
        chk("dec8_env", 64'(b0.o_env[15:0]), 64'h2000);
        chk("dec8_ph", 64'(b0.o_phase[2:0]), 64'd3);
        repeat (5) tick();
        chk("sus_hold", 64'(b0.o_phase[2:0]), 64'd3);

        for (int i = 0; i < 6; i++) begin
            gate = tbl[i].gate;
            tick();
            chk($sformatf("rel%0d_env", i),
                64'(b0.o_env[15:0]), 64'(tbl[i].env));
            chk($sformatf("rel%0d_ph", i),
                64'(b0.o_phase[2:0]), 64'(tbl[i].ph));
            chk($sformatf("rel%0d_done", i),
                64'(b0.o_done[0]), 64'(tbl[i].done));
        end

        gate = 4'b0001;
        repeat (17) tick();
        gate = 4'b0000;
        repeat (2) tick();
        chk("rt_pre", 64'(b0.o_env[15:0]), 64'h1800);
        gate = 4'b0001;
        tick();
        chk("rt0_env", 64'(b0.o_env[15:0]), 64'h0000);
        chk("rt0_ph", 64'(b0.o_phase[2:0]), 64'd1);
        chk("rt1_env", 64'(b1.o_env[15:0]), 64'h1800);
        chk("rt1_ph", 64'(b1.o_phase[2:0]), 64'd1);
        tick();
        chk("rt0_step", 64'(b0.o_env[15:0]), 64'h0800);
        chk("rt1_step", 64'(b1.o_env[15:0]), 64'h2000);
        do_reset();

        os = 1'b1; st = 3;
        gate = 4'b0001;
        tick();
        gate = 4'b0000;
        tick();
        chk("os_fall_ign", 64'(b0.o_phase[2:0]), 64'd1);
        repeat (7) tick();
        chk("os_dec", 64'(b0.o_phase[2:0]), 64'd2);
        repeat (8) tick();
        chk("os_sus", 64'(b0.o_phase[2:0]), 64'd3);
        repeat (3) tick();
        chk("os_sus4", 64'(b0.o_phase[2:0]), 64'd3);
        tick();
        chk("os_rel", 64'(b0.o_phase[2:0]), 64'd4);
        n = 0;
        while (b0.o_phase[2:0] != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("os_rel_len", 64'(n), 64'd4);
        chk("os_done", 64'(b0.o_done[0]), 64'd1);
        do_reset();
        os = 1'b0;

        as_ = '0; sl = 32'hFFFF_FFFF; rs = '0;
        gate = 4'b0001;
        tick();
        tick();
        chk("a0_env", 64'(b0.o_env[15:0]), 64'h4000);
        chk("a0_ph", 64'(b0.o_phase[2:0]), 64'd2);
        tick();
        chk("clamp_env", 64'(b0.o_env[15:0]), 64'h4000);
        chk("clamp_ph", 64'(b0.o_phase[2:0]), 64'd3);
        gate = 4'b0000;
        tick();
        tick();
        chk("r0_ph", 64'(b0.o_phase[2:0]), 64'd0);
        chk("r0_done", 64'(b0.o_done[0]), 64'd1);

        as_ = 32'h1000_0000; rs = 32'h1000_0000;
        gate = 4'b0110;
        tick();
        gate = 4'b0010;
        tick();
        chk("ch1_ph", 64'(b0.o_phase[5:3]), 64'd1);
        chk("ch1_env", 64'(b0.o_env[31:16]), 64'h0800);
        chk("ch2_ph", 64'(b0.o_phase[8:6]), 64'd4);
        tick();
        chk("ch1_env2", 64'(b0.o_env[31:16]), 64'h1000);
        chk("ch2_idle", 64'(b0.o_phase[8:6]), 64'd0);
        chk("ch2_done", 64'(b0.o_done[2]), 64'd1);
        do_reset();

        as_ = 32'h0100_0000;
        gate = 4'b0001;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        chk("arst_env", 64'(b0.o_env), 64'd0);
        chk("arst_ph", 64'(b0.o_phase), 64'd0);
        chk("arst_act", 64'(b0.o_active), 64'd0);
        chk("arst_env1", 64'(b1.o_env), 64'd0);
        gate = '0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", 64'(b0.o_active), 64'd0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 60 == 0) begin
                as_ = ($urandom_range(0, 5) == 0) ? '0
                    : ($urandom >> $urandom_range(2, 9));
                ds  = ($urandom_range(0, 5) == 0) ? '0
                    : ($urandom >> $urandom_range(2, 9));
                rs  = ($urandom_range(0, 5) == 0) ? '0
                    : ($urandom >> $urandom_range(2, 9));
                sl  = ($urandom_range(0, 3) == 0)
                    ? 32'hFFFF_FFFF : $urandom;
                st  = $urandom_range(0, 6);
                os  = ($urandom_range(0, 2) == 0);
            end
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 9) == 0)
                    gate[i] = ~gate[i];
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adsr_poly.md
Name: adsr_poly

Overview:
- Parametrised, multi-channel successor to the single-voice ADSR envelope generator.
- NUM_CH independent envelope channels share one set of envelope settings. Each channel is driven by its own gate.
- Adds two sustain modes: gate-held, or one-shot timed.
- Adds release-on-gate-fall from any phase, a selectable retrigger policy, zero-step "instant" phases, and per-channel phase/done status.
- Sits between the note/voice controller and the per-voice amplitude multipliers of the synth datapath.

Parameters:
- NUM_CH, 4, number of independent envelope channels.
- W, 32, level accumulator width. Full scale FS = 2^(W-1).
- OUT_W, 16, output width, format Q2.(OUT_W-2). FS maps to 1.0.
- TW, 32, sustain timer width.
- RETRIG_ZERO, 1, retrigger policy. 1: level restarts from 0. 0: attack continues from the current level (legato).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_gate  in  NUM_CH  per-channel gate. Rising edge triggers the channel.
- i_one_shot  in  1  mode select. 0: gate mode. 1: one-shot timed sustain.
- i_attack_step  in  W  level increment per cycle in ATTACK.
- i_decay_step  in  W  level decrement per cycle in DECAY.
- i_sustain_level  in  W  sustain level. Values > FS are clamped to FS.
- i_release_step  in  W  level decrement per cycle in RELEASE.
- i_sustain_time  in  TW  one-shot sustain length, in cycles.
- o_env  out  NUM_CH*OUT_W  packed envelopes, channel c at [c*OUT_W +: OUT_W].
- o_phase  out  NUM_CH*3  packed phase codes: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- o_active  out  NUM_CH  1 when the channel phase is not IDLE.
- o_done  out  NUM_CH  1-cycle pulse when a channel enters IDLE from RELEASE.

Behaviour:
- Reset (asynchronous, active-high) clears every channel: phase=IDLE, level L=0, timer t=0, gate_q=0. All outputs are 0.
- Each channel is a registered FSM. Settings inputs are sampled every cycle and are not latched at trigger.
- gate_q is the registered i_gate. A trigger occurs on any edge where i_gate=1 and gate_q=0. A fall occurs on any edge where i_gate=0 and gate_q=1.
- Priority per channel, per edge: trigger > fall > normal phase update.
- Trigger, from any phase including mid-envelope:
  - phase <= ATTACK, t <= 0.
  - L <= 0 if RETRIG_ZERO=1, else L is unchanged.
  - No step is applied on the trigger edge.
- Fall, gate mode only (i_one_shot=0): in ATTACK, DECAY or SUSTAIN, phase <= RELEASE and L is kept. In one-shot mode, falls are ignored.
- ATTACK:
  - tmp = L + attack_step, computed at W+1 bits.
  - If attack_step == 0 or tmp >= FS: L <= FS, phase <= DECAY.
  - Else L <= tmp.
- DECAY:
  - S = min(i_sustain_level, FS).
  - If decay_step == 0 or L < decay_step or L - decay_step <= S: L <= S, phase <= SUSTAIN, t <= 0.
  - Else L <= L - decay_step.
- SUSTAIN:
  - L holds.
  - Gate mode: stay until a fall.
  - One-shot: if t < sustain_time, t <= t+1; else phase <= RELEASE. Dwell is sustain_time+1 cycles.
  - A change of i_sustain_level during SUSTAIN is ignored.
- RELEASE:
  - If release_step == 0 or L <= release_step: L <= 0, phase <= IDLE, o_done pulses on the following cycle.
  - Else L <= L - release_step.
- IDLE: L=0. Only a trigger leaves IDLE.
- Output: o_env = {1'b0, L[W-1 -: OUT_W-1]}, so FS gives 2^(OUT_W-2). o_env, o_phase and o_active are registered functions of L and phase, with no added latency.
- Channels are fully independent. Simultaneous triggers on several channels are all honoured on the same edge.
- A 1-cycle gate pulse in gate mode gives: trigger, then on the next edge a fall, so ATTACK lasts 1 cycle followed by RELEASE from L.
- Subtractions never wrap. All compares are unsigned, and underflow cases clamp as stated above.

Test Plan:
- Reset/idle: assert i_reset mid-ATTACK -> all o_env=0, o_phase=0, o_active=0 asynchronously; after deassert, no activity without a gate edge.
- Attack/decay (W=32, OUT_W=16, attack_step=0x1000_0000, decay_step=0x0800_0000, sustain=0x4000_0000), gate held:
  - 8 ATTACK updates reach o_env=0x4000.
  - 8 DECAY updates reach o_env=0x2000 in SUSTAIN.
  - Stays in SUSTAIN while the gate is high.
- Gate-mode release: from the previous scenario drop the gate, release_step=0x1000_0000 -> o_env 0x1800, 0x1000, 0x0800, then 0x0000 with IDLE; o_done pulses exactly once.
- One-shot: i_one_shot=1, sustain_time=3, gate pulsed 1 cycle -> full A/D, SUSTAIN for exactly 4 cycles, then RELEASE to IDLE; gate fall ignored.
- Retrigger mid-RELEASE at L=0x3000_0000:
  - RETRIG_ZERO=1: next o_env=0 in ATTACK.
  - RETRIG_ZERO=0: ATTACK resumes from 0x1800.
- Boundaries:
  - attack_step=0: FS in 1 update.
  - i_sustain_level=0xFFFF_FFFF: clamped, SUSTAIN at 0x4000.
  - release_step=0: instant IDLE.
  - Two channels triggered on the same edge with different gates evolve independently.
